// File: rtl/jtdd_adpcm_ctrl.sv
// ADPCM sample sequencer for one MSM5205 voice: fetches ROM bytes page by page and feeds nibbles on vclk.
// Optional underrun counter enabled by defining JTDD_ADPCM_UNDERRUN_EN.
module jtdd_adpcm_ctrl #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic          cpu_wr,
    input  logic [1:0]    cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          sample_cen,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    adpcm_din,
    output logic          adpcm_rst,
    output logic          busy,
    output logic [7:0]    underruns
);

    // state | meaning
    // IDLE  | not playing, decoder held in reset, strobes ignored
    // REQ   | ROM request pending for addr
    // HI    | byte held, high nibble goes out on next strobe
    // LO    | low nibble goes out on next strobe, then next byte or stop
    typedef enum logic [1:0] {IDLE, REQ, HI, LO} state_t;

    localparam int OW = AW - 8;

    state_t        st;
    logic [7:0]    start_pg;
    logic [7:0]    end_pg;
    logic [7:0]    byte_r;
    logic [AW-1:0] addr;
    logic [AW-1:0] stop_addr;
    logic          ok_mask;

    logic          wr_en;
    logic          play_wr;
    logic          stop_wr;
    logic          strobe;

    assign wr_en   = cpu_cen & cpu_wr;
    assign play_wr = wr_en && (cpu_addr == 2'd0);
    assign stop_wr = wr_en && (cpu_addr == 2'd1);
    // any CPU write in the same cycle swallows the decoder strobe
    assign strobe  = sample_cen & ~wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            start_pg  <= 8'd0;
            end_pg    <= 8'd0;
            byte_r    <= 8'd0;
            addr      <= '0;
            stop_addr <= '0;
            ok_mask   <= 1'b0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            adpcm_din <= 4'd0;
            adpcm_rst <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (wr_en && cpu_addr == 2'd2) start_pg <= cpu_din;
            if (wr_en && cpu_addr == 2'd3) end_pg   <= cpu_din;

            if (play_wr) begin
                // end address is latched so page writes during playback do not disturb it
                addr      <= {start_pg, {OW{1'b0}}};
                rom_addr  <= {start_pg, {OW{1'b0}}};
                stop_addr <= {end_pg, {OW{1'b1}}};
                rom_cs    <= 1'b1;
                ok_mask   <= 1'b1;
                busy      <= 1'b1;
                adpcm_rst <= 1'b0;
                st        <= REQ;
            end else if (stop_wr) begin
                rom_cs    <= 1'b0;
                busy      <= 1'b0;
                adpcm_rst <= 1'b1;
                st        <= IDLE;
            end else begin
                case (st)
                    IDLE: ;
                    REQ: begin
                        // ok may still refer to the previous address during the first cycle
                        ok_mask <= 1'b0;
                        if (rom_ok && !ok_mask) begin
                            byte_r <= rom_data;
                            rom_cs <= 1'b0;
                            st     <= HI;
                        end
                    end
                    HI: begin
                        if (strobe) begin
                            adpcm_din <= byte_r[7:4];
                            st        <= LO;
                        end
                    end
                    LO: begin
                        if (strobe) begin
                            adpcm_din <= byte_r[3:0];
                            if (addr == stop_addr) begin
                                busy      <= 1'b0;
                                adpcm_rst <= 1'b1;
                                st        <= IDLE;
                            end else begin
                                addr     <= addr + AW'(1);
                                rom_addr <= addr + AW'(1);
                                rom_cs   <= 1'b1;
                                ok_mask  <= 1'b1;
                                st       <= REQ;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

`ifdef JTDD_ADPCM_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (rst || play_wr) begin
            underruns <= 8'd0;
        end else if (st == REQ && strobe && underruns != 8'hFF) begin
            underruns <= underruns + 8'd1;
        end
    end
`else
    assign underruns = 8'd0;
`endif

endmodule

// File: tb/tb_jtdd_adpcm_ctrl.sv
// Scoreboard bench for jtdd_adpcm_ctrl: a queue-based playback model predicts codes and ROM addresses.
module tb_jtdd_adpcm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cen = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [1:0]  cpu_addr = 2'd0;
    logic [7:0]  cpu_din = 8'd0;
    logic        sample_cen = 1'b0;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic        rom_ok = 1'b0;
    logic [3:0]  adpcm_din;
    logic        adpcm_rst;
    logic        busy;
    logic [7:0]  underruns;

    always #5 clk = ~clk;

    jtdd_adpcm_ctrl #(.AW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_cen    (cpu_cen),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .sample_cen (sample_cen),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .adpcm_din  (adpcm_din),
        .adpcm_rst  (adpcm_rst),
        .busy       (busy),
        .underruns  (underruns)
    );

    typedef struct packed {
        logic [3:0] din;
        logic       busy;
        logic [7:0] und;
        logic       cs;
        logic       was_rst;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        evq[$];
    logic [3:0]  nibq[$];
    logic [15:0] addrq[$];

    // reference model state
    bit          playing = 1'b0;
    logic [3:0]  last_code = 4'd0;
    logic [7:0]  und_m = 8'd0;
    logic [7:0]  start_m = 8'd0;
    logic [7:0]  end_m = 8'd0;
    int          restart_seq = 0;

    // ROM responder controls
    logic        ok_good = 1'b0;
    int          lat_lo = 3;
    int          lat_hi = 3;
    int          scen_period = 0;
    int          tmo_req = 0;

    // Model: playback as a list of byte addresses and a buffer of ready nibbles
    always @(posedge clk) begin
        bit          wr, pw, sw, strobe, deliver;
        exp_t        e;
        logic [15:0] a;
        wr      = cpu_cen && cpu_wr;
        pw      = wr && cpu_addr == 2'd0;
        sw      = wr && cpu_addr == 2'd1;
        strobe  = sample_cen && !wr;
        deliver = rom_ok && ok_good && !pw && !sw;
        if (rst) begin
            playing = 1'b0;
            nibq.delete();
            addrq.delete();
            last_code = 4'd0;
            und_m = 8'd0;
            start_m = 8'd0;
            end_m = 8'd0;
            restart_seq++;
        end else begin
            if (wr && cpu_addr == 2'd2) start_m = cpu_din;
            if (wr && cpu_addr == 2'd3) end_m = cpu_din;
            if (pw) begin
                addrq.delete();
                nibq.delete();
                a = {start_m, 8'h00};
                addrq.push_back(a);
                while (a != {end_m, 8'hFF}) begin
                    a = a + 16'd1;
                    addrq.push_back(a);
                end
                playing = 1'b1;
                und_m = 8'd0;
                restart_seq++;
            end else if (sw) begin
                playing = 1'b0;
                nibq.delete();
                addrq.delete();
            end else begin
                if (strobe && playing) begin
                    if (nibq.size() > 0) begin
                        last_code = nibq.pop_front();
                        if (nibq.size() == 0 && addrq.size() == 0) playing = 1'b0;
                    end else if (und_m != 8'hFF) begin
                        und_m++;
                    end
                end
                if (deliver && addrq.size() > 0) begin
                    a = addrq.pop_front();
                    nibq.push_back(a[7:4]);
                    nibq.push_back(a[3:0]);
                end
            end
        end
        if (rst || wr || sample_cen) begin
            e.din     = last_code;
            e.busy    = playing;
`ifdef JTDD_ADPCM_UNDERRUN_EN
            e.und     = und_m;
`else
            e.und     = 8'd0;
`endif
            e.cs      = playing && nibq.size() == 0;
            e.was_rst = rst;
            evq.push_back(e);
        end
    end

    // ROM slot: byte = low address byte, random latency, stale ok allowed in the first cycle
    int          rcnt = 0;
    int          rlat = 3;
    int          seen_seq = 0;
    logic [15:0] prev_addr = 16'd0;
    bit          prev_cs = 1'b0;
    always @(negedge clk) begin
        if (!rom_cs || !prev_cs || rom_addr != prev_addr || seen_seq != restart_seq) begin
            rcnt = 0;
            rlat = $urandom_range(lat_hi, lat_lo);
        end else begin
            rcnt++;
        end
        seen_seq  = restart_seq;
        prev_addr = rom_addr;
        prev_cs   = rom_cs;
        if (rom_cs && rcnt > 0 && rcnt >= rlat) begin
            rom_ok   = 1'b1;
            ok_good  = 1'b1;
            rom_data = rom_addr[7:0];
        end else begin
            rom_ok   = (rcnt == 0) && ($urandom_range(1, 0) == 1);
            ok_good  = 1'b0;
            rom_data = 8'($urandom);
        end
    end

    int scen_cnt = 0;
    always @(negedge clk) begin
        if (scen_period == 0) begin
            sample_cen = 1'b0;
        end else if (scen_cnt >= scen_period - 1) begin
            sample_cen = 1'b1;
            scen_cnt = 0;
        end else begin
            sample_cen = 1'b0;
            scen_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: address of each real ROM delivery, and outputs one cycle after every event
    int tmo_ack = 0;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rom_ok && ok_good) begin
            if (addrq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rom_addr at %0t: got %0h expected no request", $time, rom_addr);
            end else begin
                chk("rom_addr", int'(rom_addr), int'(addrq[0]));
            end
        end
        while (evq.size() > 0) begin
            e = evq.pop_front();
            chk("adpcm_din", int'(adpcm_din), int'(e.din));
            chk("busy", int'(busy), int'(e.busy));
            chk("adpcm_rst", int'(adpcm_rst), int'(!e.busy));
            chk("underruns", int'(underruns), int'(e.und));
            chk("rom_cs", int'(rom_cs), int'(e.cs));
            if (e.was_rst) chk("rst_rom_addr", int'(rom_addr), 0);
        end
        if (tmo_req != tmo_ack) begin
            tmo_ack = tmo_req;
            checks++;
            failures++;
            $display("FAIL wait_idle at %0t: busy still %0d, expected 0 within budget", $time, busy);
        end
    end

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_cen  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        @(negedge clk);
        cpu_cen  = 1'b0;
        cpu_wr   = 1'b0;
    endtask

    task automatic ungated_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_cen  = 1'b0;
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        @(negedge clk);
        cpu_wr   = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) tmo_req++;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // single page, fixed latency, 64-cycle strobes
        lat_lo = 3; lat_hi = 3;
        cpu_write(2'd2, 8'h12);
        cpu_write(2'd3, 8'h12);
        scen_period = 64;
        cpu_write(2'd0, 8'h00);
        wait_idle(40000);
        repeat (200) @(negedge clk);

        // stop after about ten strobes
        cpu_write(2'd0, 8'h00);
        repeat (10 * 64 + 20) @(negedge clk);
        cpu_write(2'd1, 8'h00);
        repeat (300) @(negedge clk);

        // wrap from FFxx to 00xx
        lat_lo = 1; lat_hi = 4;
        cpu_write(2'd2, 8'hFF);
        cpu_write(2'd3, 8'h00);
        scen_period = 12;
        cpu_write(2'd0, 8'h00);
        wait_idle(20000);

        // slow ROM: underruns
        lat_lo = 100; lat_hi = 100;
        scen_period = 64;
        cpu_write(2'd2, 8'h30);
        cpu_write(2'd3, 8'h30);
        cpu_write(2'd0, 8'h00);
        repeat (3000) @(negedge clk);

        // restart mid-sample from page 40
        lat_lo = 2; lat_hi = 5;
        cpu_write(2'd2, 8'h40);
        cpu_write(2'd0, 8'h00);
        repeat (400) @(negedge clk);
        cpu_write(2'd1, 8'h00);

        // reset while a request is pending, then a clean play
        lat_lo = 50; lat_hi = 50;
        cpu_write(2'd0, 8'h00);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat_lo = 2; lat_hi = 4;
        scen_period = 10;
        cpu_write(2'd2, 8'h05);
        cpu_write(2'd3, 8'h05);
        cpu_write(2'd0, 8'h00);
        wait_idle(8000);

        // randomized sessions with interleaved bus traffic
        for (int it = 0; it < 6; it++) begin
            r = $urandom_range(7, 0);
            if (r == 0) begin lat_lo = 30; lat_hi = 60; end
            else begin lat_lo = 1; lat_hi = 6; end
            scen_period = $urandom_range(40, 8);
            r = $urandom_range(255, 0);
            cpu_write(2'd2, 8'(r));
            cpu_write(2'd3, 8'(r + $urandom_range(1, 0)));
            cpu_write(2'd0, 8'h00);
            for (int c = 0; c < 3000; c++) begin
                r = $urandom_range(999, 0);
                if (r < 2) cpu_write(2'd1, 8'h00);
                else if (r < 4) cpu_write(2'd0, 8'h00);
                else if (r < 7) cpu_write(2'(2 + $urandom_range(1, 0)), 8'($urandom));
                else if (r < 12) ungated_write(2'($urandom_range(3, 0)), 8'($urandom));
                else @(negedge clk);
            end
            cpu_write(2'd1, 8'h00);
            repeat (20) @(negedge clk);
        end

        scen_period = 0;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
